vscale_scoreboard: RTL
======================

# vscale_scoreboard

Parametrised register scoreboard and hazard controller for the vscale pipeline. It generalises the single-stage WB bypass and load-use interlock to any number of long-latency writeback units, for example the data memory and an iterative mul/div. It sits beside the DX-stage control logic and provides:
- per-register pending tracking
- RAW/WAW stall decisions
- same-cycle completion bypass selects
- per-unit in-flight limits
- per-unit watchdog timeouts

## Interface
Parameters:
- NUM_REGS, 32, architectural registers tracked; register 0 is never pending
- ADDR_W, 5, register address width (clog2 NUM_REGS)
- NUM_UNITS, 2, long-latency writeback units
- UNIT_W, 1, unit index width (clog2 NUM_UNITS, minimum 1)
- DEPTH, 2, maximum in-flight operations per unit
- TIMEOUT, 64, cycles without completion before a unit times out

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- issue_valid  in  1  DX instruction issuing this cycle
- issue_wr  in  1  issuing instruction writes rd
- issue_rd  in  ADDR_W  destination register
- issue_long  in  1  result comes from a long-latency unit
- issue_unit  in  UNIT_W  target unit when issue_long is set
- rs1_addr, rs2_addr  in  ADDR_W  source registers
- rs1_used, rs2_used  in  1  source actually read
- wb_valid  in  NUM_UNITS  unit u completes this cycle
- wb_rd  in  NUM_UNITS*ADDR_W  destination of each completion (unit u at bits [u*ADDR_W +: ADDR_W])
- flush  in  1  exception/redirect; drop all tracking
- stall_DX  out  1  DX must hold
- bypass_rs1, bypass_rs2  out  1  operand taken from a same-cycle completion
- bypass_rs1_sel, bypass_rs2_sel  out  UNIT_W  completing unit supplying the operand
- pending  out  NUM_REGS  registered pending mask
- unit_full  out  NUM_UNITS  unit has DEPTH operations in flight
- busy  out  1  any bit of pending set
- timeout  out  NUM_UNITS  sticky watchdog flag per unit

## Operation
State:
- pending[NUM_REGS]
- owner[NUM_REGS] (UNIT_W each)
- per unit: cnt (0..DEPTH), wdog (0..TIMEOUT), timeout

Accepted issue:
- An issue is accepted when issue_valid && !stall_DX && !flush. An issue with issue_valid && stall_DX is ignored; no state changes.
- If issue_long && issue_wr && issue_rd != 0: set pending[issue_rd] and set owner[issue_rd] = issue_unit.
- If issue_long: cnt[issue_unit] increments.

Completion (wb_valid[u]):
- Clears pending[wb_rd_u] only if owner matches u.
- cnt[u] decrements, saturating at 0. A wb_valid while cnt = 0 is ignored.
- Same register set by an issue and cleared by a completion in the same cycle: the set wins.
- Increment and decrement of one unit's cnt in the same cycle: cnt is unchanged.

Hazards (combinational):
- hit_rsX = rsX_used && rsX_addr != 0 && pending[rsX_addr].
- If a wb_valid[u] with wb_rd_u == rsX_addr and owner == u exists this cycle, then: bypass_rsX = 1, bypass_rsX_sel = u, and no stall for that operand. The lowest u wins if several match.
- stall_DX is asserted on any of:
  - unbypassed hit_rs1 or hit_rs2
  - WAW: issue_valid && issue_wr && pending[issue_rd] with no matching completion this cycle
  - structural: issue_valid && issue_long && unit_full[issue_unit] && !wb_valid[issue_unit]
- stall_DX is forced to 0 while flush = 1.

unit_full[u] = (cnt[u] == DEPTH), taken from registered state.

Watchdog, per unit:
- If cnt > 0 and no wb_valid, wdog increments.
- wdog is reset to 0 on wb_valid or when cnt = 0.
- wdog == TIMEOUT-1 with no completion sets timeout[u]. timeout[u] holds until flush or reset.

Flush, synchronous:
- Clears pending, cnt, wdog and timeout.
- Overrides any issue or completion in the same cycle.

## Timing
- Reset (reset_n = 0 at an edge): pending = 0, owner = 0, cnt = 0, wdog = 0, timeout = 0. Hence busy = 0 and unit_full = 0. stall_DX and bypass_* depend only on the inputs and are 0 for any input, because pending = 0 and unit_full = 0. Reset takes priority over flush, issue and completion.
- An issue accepted at edge N makes pending visible from cycle N+1. A dependent instruction in DX during cycle N+1 stalls.
- A completion in cycle M bypasses combinationally in cycle M. pending clears at edge M+1.
- stall_DX, bypass_* and bypass_*_sel are combinational from the inputs and registered state. There is no registered output latency.
- Minimum issue-to-completion latency is 1 cycle.
- Reset mid-operation drops all in-flight tracking. The units must be reset concurrently.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with random inputs -> pending = 0, busy = 0, timeout = 0, stall_DX = 0.
- Load-use: issue long to unit 0 with rd = 5; next cycle rs1_addr = 5, rs1_used = 1 -> stall_DX = 1. Then wb_valid[0] with rd 5 -> stall_DX = 0, bypass_rs1 = 1, bypass_rs1_sel = 0, and pending[5] = 0 the next cycle.
- Structural: with DEPTH = 2, issue 2 long ops to unit 1 (rd 3, rd 4) -> unit_full[1] = 1; a third issue to unit 1 -> stall_DX = 1. The same cycle with wb_valid[1] -> no stall and cnt stays at 2.
- Owner / WAW: rd 7 issued to unit 0, then a WAW issue of rd 7 to unit 1 -> stall_DX = 1 until wb_valid[0] with rd 7. In the completion cycle the issue is accepted, pending[7] stays 1 and owner becomes 1. A later wb_valid[0] with rd 7 -> pending[7] stays 1.
- x0: issue long with rd = 0, then read rs1 = 0 -> no pending bit and no stall, while cnt increments.
- Timeout / flush: TIMEOUT = 8, one op in flight on unit 0 with no completion -> timeout[0] = 1 after 8 cycles. Then flush -> timeout = 0, pending = 0, busy = 0 the next cycle.

Source files
------------

// File: rtl/vscale_scoreboard.sv
// vscale_scoreboard: per-register pending tracking and hazard
// control for long-latency writeback units beside the DX stage.
module vscale_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_UNITS = 2,
  parameter int UNIT_W    = 1,
  parameter int DEPTH     = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        issue_valid,
  input  logic                        issue_wr,
  input  logic [ADDR_W-1:0]           issue_rd,
  input  logic                        issue_long,
  input  logic [UNIT_W-1:0]           issue_unit,
  input  logic [ADDR_W-1:0]           rs1_addr,
  input  logic [ADDR_W-1:0]           rs2_addr,
  input  logic                        rs1_used,
  input  logic                        rs2_used,
  input  logic [NUM_UNITS-1:0]        wb_valid,
  input  logic [NUM_UNITS*ADDR_W-1:0] wb_rd,
  input  logic                        flush,
  output logic                        stall_DX,
  output logic                        bypass_rs1,
  output logic                        bypass_rs2,
  output logic [UNIT_W-1:0]           bypass_rs1_sel,
  output logic [UNIT_W-1:0]           bypass_rs2_sel,
  output logic [NUM_REGS-1:0]         pending,
  output logic [NUM_UNITS-1:0]        unit_full,
  output logic                        busy,
  output logic [NUM_UNITS-1:0]        timeout
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [UNIT_W-1:0]    owner_q [NUM_REGS];
  logic [UNIT_W-1:0]    owner_d [NUM_REGS];
  logic [CNT_W-1:0]     cnt_q [NUM_UNITS];
  logic [CNT_W-1:0]     cnt_d [NUM_UNITS];
  logic [WD_W-1:0]      wdog_q [NUM_UNITS];
  logic [WD_W-1:0]      wdog_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] timeout_q, timeout_d;
  logic [ADDR_W-1:0]    wb_addr [NUM_UNITS];
  logic [NUM_UNITS-1:0] wb_live, wb_own, full;
  logic [NUM_UNITS-1:0] inc, dec;
  logic                 hit1, hit2, m1, m2, mw;
  logic                 waw, strct, accept;
  logic [UNIT_W-1:0]    sel1, sel2;

  // Decode completions; a completion on an idle unit is ignored
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      wb_addr[u] = wb_rd[u*ADDR_W +: ADDR_W];
      wb_live[u] = wb_valid[u] && (cnt_q[u] != '0);
      wb_own[u]  = wb_live[u] &&
                   (owner_q[wb_addr[u]] == UNIT_W'(u));
      full[u]    = (cnt_q[u] == CNT_W'(DEPTH));
    end
  end

  // Hazard detection; descending scan lets the lowest unit win
  always_comb begin
    m1   = 1'b0;
    m2   = 1'b0;
    mw   = 1'b0;
    sel1 = '0;
    sel2 = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (wb_own[u] && wb_addr[u] == rs1_addr) begin
        m1   = 1'b1;
        sel1 = UNIT_W'(u);
      end
      if (wb_own[u] && wb_addr[u] == rs2_addr) begin
        m2   = 1'b1;
        sel2 = UNIT_W'(u);
      end
      if (wb_own[u] && wb_addr[u] == issue_rd)
        mw = 1'b1;
    end
    hit1 = rs1_used && (rs1_addr != '0) &&
           pending_q[rs1_addr];
    hit2 = rs2_used && (rs2_addr != '0) &&
           pending_q[rs2_addr];
    waw  = issue_valid && issue_wr &&
           pending_q[issue_rd] && !mw;
    strct = issue_valid && issue_long &&
            full[issue_unit] && !wb_valid[issue_unit];
    stall_DX = !flush && ((hit1 && !m1) ||
               (hit2 && !m2) || waw || strct);
    bypass_rs1     = hit1 && m1;
    bypass_rs2     = hit2 && m2;
    bypass_rs1_sel = sel1;
    bypass_rs2_sel = sel2;
    accept = issue_valid && !stall_DX && !flush;
  end

  // Next state: clears first so a same-cycle set wins
  always_comb begin
    pending_d = pending_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    inc       = '0;
    dec       = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (wb_own[u])
        pending_d[wb_addr[u]] = 1'b0;
    end
    if (accept && issue_long && issue_wr &&
        issue_rd != '0) begin
      pending_d[issue_rd] = 1'b1;
      owner_d[issue_rd]   = issue_unit;
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      inc[u] = accept && issue_long &&
               (issue_unit == UNIT_W'(u));
      dec[u] = wb_live[u];
      if (inc[u] && !dec[u])
        cnt_d[u] = cnt_q[u] + CNT_W'(1);
      else if (dec[u] && !inc[u])
        cnt_d[u] = cnt_q[u] - CNT_W'(1);
      if (wb_valid[u] || cnt_q[u] == '0) begin
        wdog_d[u] = '0;
      end else begin
        if (wdog_q[u] == WD_W'(TIMEOUT - 1))
          timeout_d[u] = 1'b1;
        if (wdog_q[u] != WD_W'(TIMEOUT))
          wdog_d[u] = wdog_q[u] + WD_W'(1);
      end
    end
    if (flush) begin
      pending_d = '0;
      timeout_d = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        cnt_d[u]  = '0;
        wdog_d[u] = '0;
      end
    end
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= '0;
      timeout_q <= '0;
      for (int r = 0; r < NUM_REGS; r++)
        owner_q[r] <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        cnt_q[u]  <= '0;
        wdog_q[u] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
    end
  end

  assign pending   = pending_q;
  assign unit_full = full;
  assign busy      = |pending_q;
  assign timeout   = timeout_q;

endmodule
